systolic_result_writer: RTL and testbench

Drain stage for the 2x2 systolic multiplier. On a start pulse it snapshots the four 32-bit PE results c00, c01, c10 and c11. It then writes them row-major into a 4-entry single-port block memory through the same ena/wea/addra/dina port shape the array's operand memories use, and signals completion. It is the writer counterpart of the operand-fetch side. An optional read-back pass re-reads the memory and flags any mismatch.

---
 rtl/systolic_result_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_systolic_result_writer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_writer.sv
`default_nettype none
// =============================================================================
// Module   : systolic_result_writer
// Brief    : Drain stage for the 2x2 systolic multiplier. On an accepted start
//            the four PE results are snapshotted and written row-major
//            (c00, c01, c10, c11) into a 4-entry single-port memory through an
//            ena/wea/addra/dina/douta port. Addresses start at BASE_ADDR and
//            wrap modulo 2^ADDR_W.
//            Optional feature macro: SYS_RESULT_READBACK_EN. When defined, a
//            read-back pass re-reads the four words and raises a sticky err
//            flag on any mismatch. When undefined, err is tied low and douta
//            is ignored.
// Revision : 1.0 - initial release
// =============================================================================
module systolic_result_writer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 2,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] c00,
    input  logic [DATA_W-1:0] c01,
    input  logic [DATA_W-1:0] c10,
    input  logic [DATA_W-1:0] c11,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
`ifdef SYS_RESULT_READBACK_EN
    localparam logic [1:0] S_READ  = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] C_LAST_WORD = 3'd3;
`ifdef SYS_RESULT_READBACK_EN
    // Index 4 in READ issues no access; it only waits for the last douta.
    localparam logic [2:0] C_READ_DRAIN = 3'd4;
`endif
    localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [DATA_W-1:0] r_snap [4];
    logic [DATA_W-1:0] w_src  [4];
    logic              w_accept;

    logic              w_ena_nxt;
    logic              w_wea_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [ADDR_W-1:0] w_addra_nxt;
    logic [DATA_W-1:0] w_dina_nxt;

    assign w_accept = (r_state == S_IDLE) && start;

    // Write-data source: live inputs on the accept cycle (snapshot not yet loaded), snapshot afterwards.
    always_comb begin
        w_src[0] = w_accept ? c00 : r_snap[0];
        w_src[1] = w_accept ? c01 : r_snap[1];
        w_src[2] = w_accept ? c10 : r_snap[2];
        w_src[3] = w_accept ? c11 : r_snap[3];
    end

    // Next-state and word-index sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WRITE;
                    w_idx_nxt   = 3'd0;
                end
            end
            S_WRITE: begin
                if (r_idx == C_LAST_WORD) begin
`ifdef SYS_RESULT_READBACK_EN
                    w_state_nxt = S_READ;
`else
                    w_state_nxt = S_DONE;
`endif
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end
`ifdef SYS_RESULT_READBACK_EN
            S_READ: begin
                if (r_idx == C_READ_DRAIN) begin
                    w_state_nxt = S_DONE;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 3'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every port can be registered.
    always_comb begin
        w_ena_nxt   = 1'b0;
        w_wea_nxt   = 1'b0;
        w_addra_nxt = '0;
        w_dina_nxt  = '0;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_DONE);
        case (w_state_nxt)
            S_WRITE: begin
                w_ena_nxt   = 1'b1;
                w_wea_nxt   = 1'b1;
                w_addra_nxt = C_BASE + ADDR_W'(w_idx_nxt);
                w_dina_nxt  = w_src[w_idx_nxt[1:0]];
            end
`ifdef SYS_RESULT_READBACK_EN
            S_READ: begin
                if (w_idx_nxt != C_READ_DRAIN) begin
                    w_ena_nxt   = 1'b1;
                    w_addra_nxt = C_BASE + ADDR_W'(w_idx_nxt);
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // State and word-index register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ena   <= 1'b0;
            wea   <= 1'b0;
            addra <= '0;
            dina  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ena   <= w_ena_nxt;
            wea   <= w_wea_nxt;
            addra <= w_addra_nxt;
            dina  <= w_dina_nxt;
            busy  <= w_busy_nxt;
            done  <= w_done_nxt;
        end
    end

    // Result snapshot, captured only when start is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_accept) begin
            r_snap[0] <= c00;
            r_snap[1] <= c01;
            r_snap[2] <= c10;
            r_snap[3] <= c11;
        end
    end

`ifdef SYS_RESULT_READBACK_EN
    logic       r_cmp_pend;
    logic [1:0] r_cmp_idx;
    logic       r_err;

    // Delay each issued read by one cycle so it lines up with its douta word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cmp_pend <= 1'b0;
            r_cmp_idx  <= 2'd0;
        end else begin
            r_cmp_pend <= (r_state == S_READ) && (r_idx != C_READ_DRAIN);
            r_cmp_idx  <= r_idx[1:0];
        end
    end

    // Sticky mismatch flag; a newly accepted start clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (r_cmp_pend && (douta != r_snap[r_cmp_idx])) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_douta;
    assign w_unused_douta = ^douta;
    assign err            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_writer.sv
`default_nettype none
// =============================================================================
// Module   : tb_systolic_result_writer
// Brief    : Self-checking bench for systolic_result_writer. Two instances
//            (BASE_ADDR 0 and 3) share stimulus, each with its own 4-entry
//            memory model (1-cycle read latency, optional corruption of reads
//            of address 2). Table vectors, hand-written corner sequences and
//            randomized operations against a reference memory image.
// Revision : 1.0 - initial release
// =============================================================================
module tb_systolic_result_writer;

`ifdef SYS_RESULT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int L = RB ? 10 : 5;
    localparam logic [31:0] C_BAD = 32'h0000DEAD;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             start   = 1'b0;
    logic [3:0][31:0] c       = '0;
    logic [1:0]       busy, done, err, ena, wea;
    logic [1:0][1:0]  addra;
    logic [1:0][31:0] dina;
    logic [1:0][31:0] douta   = '0;
    logic [31:0]      mem [2][4];
    bit               corrupt = 1'b0;
    int               cyc     = 0;
    int               wr_cnt   [2] = '{0, 0};
    int               rd_cnt   [2] = '{0, 0};
    int               done_cnt [2] = '{0, 0};
    int               wr_last  [2] = '{0, 0};
    int               checks = 0;
    int               errors = 0;

    typedef struct {
        logic [3:0][31:0] v;
        bit               corr;
        logic [3:0][31:0] e0;
        logic [3:0][31:0] e3;
        bit               err0;
        bit               err3;
    } vec_t;

    vec_t             tbl [5];
    logic [3:0][31:0] v, v2, e0, e3;
    bit               corr;
    int               t0;
    int               wb [2];
    int               db [2];

    always #5 clk = ~clk;

    systolic_result_writer #(.DATA_W(32), .ADDR_W(2), .BASE_ADDR(0)) u_base0 (
        .clk(clk), .rst(rst_n), .start(start),
        .c00(c[0]), .c01(c[1]), .c10(c[2]), .c11(c[3]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .ena(ena[0]), .wea(wea[0]),
        .addra(addra[0]), .dina(dina[0]), .douta(douta[0])
    );

    systolic_result_writer #(.DATA_W(32), .ADDR_W(2), .BASE_ADDR(3)) u_base3 (
        .clk(clk), .rst(rst_n), .start(start),
        .c00(c[0]), .c01(c[1]), .c10(c[2]), .c11(c[3]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .ena(ena[1]), .wea(wea[1]),
        .addra(addra[1]), .dina(dina[1]), .douta(douta[1])
    );

    // Memory models plus activity counters; cyc is the number of the edge being processed.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (ena[i]) begin
                if (wea[i]) begin
                    mem[i][addra[i]] <= dina[i];
                    wr_cnt[i]        <= wr_cnt[i] + 1;
                    wr_last[i]       <= cyc;
                end else begin
                    douta[i]  <= (corrupt && addra[i] == 2'd2) ? C_BAD : mem[i][addra[i]];
                    rd_cnt[i] <= rd_cnt[i] + 1;
                end
            end
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] w4(input logic [31:0] a0, input logic [31:0] a1,
                                             input logic [31:0] a2, input logic [31:0] a3);
        logic [3:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    // Reference memory image: word k of the row-major result lands at (base + k) mod 4.
    function automatic logic [3:0][31:0] ref_image(input logic [3:0][31:0] vals, input int base);
        logic [3:0][31:0] img;
        for (int k = 0; k < 4; k++) img[(base + k) % 4] = vals[k];
        return img;
    endfunction

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " busy"}, busy, 2'b00);
        chk({nm, " done"}, done, 2'b00);
        chk({nm, " err"}, err, 2'b00);
        chk({nm, " ena/wea"}, {ena, wea}, 4'h0);
        chk({nm, " addra"}, {addra[1], addra[0]}, 4'h0);
        chk({nm, " dina"}, {dina[1], dina[0]}, 64'h0);
    endtask

    // One complete operation, started at a negedge; expectations come from the caller.
    task automatic do_op(input string nm, input logic [3:0][31:0] vals, input bit cr, input bit noise,
                         input logic [3:0][31:0] x0, input logic [3:0][31:0] x3,
                         input bit xe0, input bit xe3);
        int         s0, done_at, fall_at;
        int         w0 [2], r0 [2], d0 [2];
        logic [1:0] err_at;
        c       = vals;
        corrupt = cr;
        start   = 1'b1;
        s0      = cyc;
        for (int i = 0; i < 2; i++) begin
            w0[i] = wr_cnt[i]; r0[i] = rd_cnt[i]; d0[i] = done_cnt[i];
        end
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy@T0"}, busy, 2'b11);
        chk({nm, " err cleared@T0"}, err, 2'b00);
        chk({nm, " first addr"}, {addra[1], addra[0]}, {2'd3, 2'd0});
        chk({nm, " first data"}, {dina[1], dina[0]}, {vals[0], vals[0]});
        done_at = -1;
        fall_at = -1;
        err_at  = 2'b00;
        for (int k = 0; k < 3 * L && fall_at < 0; k++) begin
            if (done[0] && done_at < 0) begin
                done_at = cyc;
                err_at  = err;
            end
            if (!busy[0]) fall_at = cyc;
            if (noise && cyc <= s0 + L) begin
                c     = {$urandom, $urandom, $urandom, $urandom};
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (fall_at < 0) @(negedge clk);
        end
        start = 1'b0;
        chk({nm, " latency"}, done_at - s0, L);
        chk({nm, " busy fall"}, fall_at - s0, L + 1);
        chk({nm, " err@done b0"}, err_at[0], xe0);
        chk({nm, " err@done b3"}, err_at[1], xe3);
        chk({nm, " last write edge"}, wr_last[0] - s0, 4);
        for (int i = 0; i < 2; i++) begin
            chk({nm, " writes"}, wr_cnt[i] - w0[i], 4);
            chk({nm, " reads"}, rd_cnt[i] - r0[i], RB ? 4 : 0);
            chk({nm, " dones"}, done_cnt[i] - d0[i], 1);
        end
        for (int a = 0; a < 4; a++) begin
            chk({nm, " mem b0"}, mem[0][a], x0[a]);
            chk({nm, " mem b3"}, mem[1][a], x3[a]);
        end
    endtask

    initial begin
        tbl[0] = '{w4(32'h11, 32'h22, 32'h33, 32'h44), 1'b0,
                   w4(32'h11, 32'h22, 32'h33, 32'h44), w4(32'h22, 32'h33, 32'h44, 32'h11), 1'b0, 1'b0};
        tbl[1] = '{w4(32'hA1, 32'hB2, 32'hC3, 32'hD4), 1'b1,
                   w4(32'hA1, 32'hB2, 32'hC3, 32'hD4), w4(32'hB2, 32'hC3, 32'hD4, 32'hA1), 1'b1, 1'b1};
        tbl[2] = '{w4(32'h1, 32'h2, C_BAD, 32'h4), 1'b1,
                   w4(32'h1, 32'h2, C_BAD, 32'h4), w4(32'h2, C_BAD, 32'h4, 32'h1), 1'b0, 1'b1};
        tbl[3] = '{w4(32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7FFFFFFF), 1'b0,
                   w4(32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7FFFFFFF),
                   w4(32'h0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF), 1'b0, 1'b0};
        tbl[4] = '{w4(32'h5, 32'h6, 32'h7, C_BAD), 1'b1,
                   w4(32'h5, 32'h6, 32'h7, C_BAD), w4(32'h6, 32'h7, C_BAD, 32'h5), 1'b1, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, each followed by a sticky-err check while idle
        for (int n = 0; n < 5; n++) begin
            do_op("tbl", tbl[n].v, tbl[n].corr, 1'b0, tbl[n].e0, tbl[n].e3,
                  RB & tbl[n].err0, RB & tbl[n].err3);
            repeat (3) @(negedge clk);
            chk("tbl err sticky", err, {RB & tbl[n].err3, RB & tbl[n].err0});
        end

        // Busy rejection and snapshot: c00 changes at T1, second start at T2
        corrupt = 1'b0;
        c       = w4(32'h11, 32'h22, 32'h33, 32'h44);
        start   = 1'b1;
        t0      = cyc;
        wb[0] = wr_cnt[0]; db[0] = done_cnt[0];
        @(negedge clk); start = 1'b0; c[0] = 32'hFF;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (L + 4) @(negedge clk);
        chk("rej mem b0[0]", mem[0][0], 32'h11);
        chk("rej mem b3[3]", mem[1][3], 32'h11);
        chk("rej writes", wr_cnt[0] - wb[0], 4);
        chk("rej dones", done_cnt[0] - db[0], 1);
        chk("rej idle", busy, 2'b00);

        // Reset mid-write: rst low sampled at T2
        c     = w4(32'h55, 32'h66, 32'h77, 32'h88);
        start = 1'b1;
        t0    = cyc;
        wb[0] = wr_cnt[0]; db[0] = done_cnt[0];
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        @(negedge clk); rst_n = 1'b1;
        repeat (L + 4) @(negedge clk);
        chk("midrst writes", wr_cnt[0] - wb[0], 2);
        chk("midrst last write", wr_last[0] - t0, 2);
        chk("midrst dones", done_cnt[0] - db[0], 0);
        chk("midrst mem0", mem[0][0], 32'h55);
        chk("midrst mem1", mem[0][1], 32'h66);
        chk("midrst mem2 kept", mem[0][2], 32'h33);

        // Start held high: retrigger on the first IDLE cycle after DONE
        v     = w4(32'h1001, 32'h1002, 32'h1003, 32'h1004);
        v2    = w4(32'h2001, 32'h2002, 32'h2003, 32'h2004);
        c     = v;
        start = 1'b1;
        t0    = cyc;
        wb[0] = wr_cnt[0]; db[0] = done_cnt[0];
        repeat (L + 1) @(negedge clk);
        c = v2;
        @(negedge clk); start = 1'b0;
        repeat (L + 4) @(negedge clk);
        chk("hold writes", wr_cnt[0] - wb[0], 8);
        chk("hold dones", done_cnt[0] - db[0], 2);
        chk("hold last write", wr_last[0] - t0, L + 5);
        for (int a = 0; a < 4; a++) chk("hold mem b0", mem[0][a], v2[a]);

        // Randomized operations with input noise and ignored starts while busy
        for (int n = 0; n < 20; n++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 3)] = C_BAD;
            corr = 1'($urandom_range(0, 1));
            e0   = ref_image(v, 0);
            e3   = ref_image(v, 3);
            do_op("rnd", v, corr, 1'b1, e0, e3,
                  RB && corr && (e0[2] != C_BAD), RB && corr && (e3[2] != C_BAD));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
